// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch with in-order response queue and redirect flush
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);
   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] q_cnt_q, q_cnt_d;
   logic [PW-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d;
   logic [PW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
   logic [31:0]   a_mem  [DEPTH];
   logic [31:0]   q_data [DEPTH];
   logic [31:0]   q_pc   [DEPTH];

   logic          req_fire, rsp_fire, rsp_keep, a_push, q_pop;
   logic [CW:0]   credits_used;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign instr_valid = (q_cnt_q != '0);
   assign instr_out   = instr_valid ? q_data[q_rd_q] : '0;
   assign instr_pc    = instr_valid ? q_pc[q_rd_q]   : '0;
   assign q_pop       = instr_valid && instr_ready;

   // A slot being popped this cycle is free for a new request, so one fetch per cycle is sustainable.
   assign credits_used   = {1'b0, inflight_q} + {1'b0, q_cnt_q} - {{CW{1'b0}}, q_pop};
   assign imem_req_valid = !reset && (credits_used < DEPTH_C);
   assign imem_req_addr  = pc_q;

   assign req_fire = imem_req_valid && imem_req_ready;
   assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
   assign rsp_keep = rsp_fire && !redirect_valid && (drop_q == '0);
   assign a_push   = req_fire && !redirect_valid;

   always_comb begin
      pc_d       = pc_q;
      drop_d     = drop_q;
      q_cnt_d    = q_cnt_q;
      a_wr_d     = a_wr_q;
      a_rd_d     = a_rd_q;
      q_wr_d     = q_wr_q;
      q_rd_d     = q_rd_q;
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_valid) begin
         // Everything still in flight after this edge belongs to the old stream.
         pc_d    = redirect_pc & 32'hFFFF_FFFC;
         drop_d  = inflight_d;
         q_cnt_d = '0;
         a_wr_d  = '0;
         a_rd_d  = '0;
         q_wr_d  = '0;
         q_rd_d  = '0;
      end else begin
         if (req_fire) pc_d = pc_q + 32'd4;
         if (rsp_fire && (drop_q != '0)) drop_d = drop_q - 1'b1;
         if (a_push) a_wr_d = ptr_inc(a_wr_q);
         if (rsp_keep) begin
            a_rd_d = ptr_inc(a_rd_q);
            q_wr_d = ptr_inc(q_wr_q);
         end
         if (q_pop) q_rd_d = ptr_inc(q_rd_q);
         q_cnt_d = q_cnt_q + CW'(rsp_keep) - CW'(q_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         q_cnt_q    <= '0;
         a_wr_q     <= '0;
         a_rd_q     <= '0;
         q_wr_q     <= '0;
         q_rd_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         q_cnt_q    <= q_cnt_d;
         a_wr_q     <= a_wr_d;
         a_rd_q     <= a_rd_d;
         q_wr_q     <= q_wr_d;
         q_rd_q     <= q_rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (a_push) a_mem[a_wr_q] <= pc_q;
      if (rsp_keep) begin
         q_data[q_wr_q] <= imem_rsp_data;
         q_pc[q_wr_q]   <= a_mem[a_rd_q];
      end
   end
endmodule
